// File: rtl/clock_switch_sequencer_if.sv
// ---------------------------------------------------------------------------
// clock_switch_sequencer_if
//
// Purpose: bundles the request, PLL lock and control/status signals of the
// clock switch sequencer. Clock and reset stay plain ports on the module.
//
// Signals:
//   SwitchEnable     request: 1 means a clock should be running
//   SwitchSelect     request: index of the wanted reference clock
//   PLL_Lock         asynchronous PLL lock indication
//   Mux_Select       select for the external glitch-free mux
//   Mux_Enable       mux output enable / clock gate
//   PLL_PowerDown_N  0 powers the PLL down
//   Reset_N_OUT      reset request for the selected clock domain
//   Locked           1 only while the sequencer is in RUN
//   Timeout_Err      sticky lock-timeout flag
//   Sel_Err          sticky out-of-range select flag
//   Retry_Count      saturating count of lock losses seen in RUN
//   State            encoded sequencer state
//
// Handshake: there is no valid/ready pair. SwitchEnable and SwitchSelect are
// levels that the sequencer samples every cycle; a request is complete when
// Locked is 1, and any change of the levels starts a new sequence.
//
// Modports: master drives the request and lock, slave is the sequencer.
// ---------------------------------------------------------------------------
interface clock_switch_sequencer_if #(
  parameter int SEL_W   = 2,
  parameter int RETRY_W = 4
);
  logic               SwitchEnable;
  logic [SEL_W-1:0]   SwitchSelect;
  logic               PLL_Lock;
  logic [SEL_W-1:0]   Mux_Select;
  logic               Mux_Enable;
  logic               PLL_PowerDown_N;
  logic               Reset_N_OUT;
  logic               Locked;
  logic               Timeout_Err;
  logic               Sel_Err;
  logic [RETRY_W-1:0] Retry_Count;
  logic [2:0]         State;

  modport master (
    output SwitchEnable, SwitchSelect, PLL_Lock,
    input  Mux_Select, Mux_Enable, PLL_PowerDown_N, Reset_N_OUT,
    input  Locked, Timeout_Err, Sel_Err, Retry_Count, State
  );

  modport slave (
    input  SwitchEnable, SwitchSelect, PLL_Lock,
    output Mux_Select, Mux_Enable, PLL_PowerDown_N, Reset_N_OUT,
    output Locked, Timeout_Err, Sel_Err, Retry_Count, State
  );
endinterface

// File: rtl/clock_switch_sequencer.sv
// ---------------------------------------------------------------------------
// clock_switch_sequencer
//
// Purpose: selects one of NUM_INPUTS reference clocks for a downstream PLL
// and sequences every change: gate, power down, switch, power up, wait for
// lock (with timeout), hold reset, release. Lock loss in RUN restarts the
// sequence on the same target and is counted.
//
// Ports:
//   Clock    control clock, every register is clocked here
//   Reset_N  asynchronous active-low reset
//   bus      clock_switch_sequencer_if.slave (request, lock, mux/PLL
//            control, reset request and status; see the interface file)
//
// Configuration macro: CLOCK_SWITCH_AUTO_FALLBACK_EN
//   defined   - a lock timeout on a non-default target retries once on
//               DEFAULT_SEL; a timeout on DEFAULT_SEL goes to FAULT
//   undefined - every lock timeout goes to FAULT
//
// State encoding: IDLE=0 GATE=1 SETTLE=2 WAIT_LOCK=3 HOLD=4 RUN=5 FAULT=6
// ---------------------------------------------------------------------------
module clock_switch_sequencer #(
  parameter int NUM_INPUTS   = 4,
  parameter int SEL_W        = 2,
  parameter int DEFAULT_SEL  = 0,
  parameter int PD_CYCLES    = 4,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int RST_HOLD     = 8,
  parameter int RETRY_W      = 4
) (
  input  logic                     Clock,
  input  logic                     Reset_N,
  clock_switch_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GATE   = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_HOLD   = 3'd4,
    S_RUN    = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  // One down-counter serves every timed state, so it is sized for the
  // longest of the three intervals.
  localparam int CNT_MAX =
    (LOCK_TIMEOUT > PD_CYCLES) ?
      ((LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD) :
      ((PD_CYCLES > RST_HOLD) ? PD_CYCLES : RST_HOLD);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [SEL_W:0]   NUM_L   = (SEL_W+1)'(NUM_INPUTS);
  localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEFAULT_SEL);

  localparam logic [CNT_W-1:0] LOAD_PD   = CNT_W'(PD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_LOCK = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOAD_HOLD = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [RETRY_W-1:0] RETRY_MAX = {RETRY_W{1'b1}};
  localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);

  // ---------------------------------------------------------------------
  // Input sampling. Request levels get one register stage so nothing in
  // the FSM is combinational from a pin; PLL_Lock is asynchronous and gets
  // a two-flop synchroniser.
  // ---------------------------------------------------------------------
  logic             en_q;
  logic [SEL_W-1:0] sel_q;
  logic             lock_s1;
  logic             lock_s2;

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      en_q    <= 1'b0;
      sel_q   <= '0;
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      en_q    <= bus.SwitchEnable;
      sel_q   <= bus.SwitchSelect;
      lock_s1 <= bus.PLL_Lock;
      lock_s2 <= lock_s1;
    end
  end

  // Range check of the sampled select; out-of-range requests map to the
  // default input.
  logic             sel_ok;
  logic [SEL_W-1:0] sel_tgt;

  assign sel_ok  = ({1'b0, sel_q} < NUM_L);
  assign sel_tgt = sel_ok ? sel_q : DEF_SEL;

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_t             state;
  state_t             ns;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_load;

  // target is the input actually being switched to; req_sel is the raw
  // request that produced it. Change detection compares against req_sel so
  // an out-of-range request or a fallback does not look like a new request
  // every cycle.
  logic [SEL_W-1:0]   target;
  logic [SEL_W-1:0]   req_sel;
  logic               sel_err_r;
  logic               to_err_r;
  logic [RETRY_W-1:0] retry_r;

  logic [SEL_W-1:0]   target_nxt;
  logic [SEL_W-1:0]   req_nxt;
  logic               sel_err_nxt;
  logic               to_err_nxt;
  logic [RETRY_W-1:0] retry_nxt;

  logic [SEL_W-1:0]   mux_sel_r;
  logic               mux_en_r;
  logic               pd_n_r;
  logic               rst_out_r;
  logic               locked_r;

  logic [SEL_W-1:0]   mux_sel_d;
  logic               mux_en_d;
  logic               pd_n_d;
  logic               rst_out_d;
  logic               locked_d;

  // ---------------------------------------------------------------------
  // Process 1: state register and interval counter. The counter reloads on
  // every state change and otherwise counts down to zero and stays there.
  // ---------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= ns;
      if (ns != state) begin
        cnt <= cnt_load;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  always_comb begin
    cnt_load = '0;
    case (ns)
      S_GATE,
      S_SETTLE: cnt_load = LOAD_PD;
      S_WAIT:   cnt_load = LOAD_LOCK;
      S_HOLD:   cnt_load = LOAD_HOLD;
      default:  cnt_load = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Process 2: next state, plus the target/flag updates that belong to
  // each transition. Disable beats lock loss, which beats a select change;
  // lock loss and a select change together still latch the new target.
  // ---------------------------------------------------------------------
  always_comb begin
    ns          = state;
    target_nxt  = target;
    req_nxt     = req_sel;
    sel_err_nxt = sel_err_r;
    to_err_nxt  = to_err_r;
    retry_nxt   = retry_r;

    if (state != S_IDLE && !en_q) begin
      ns = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (en_q) begin
            ns         = S_GATE;
            req_nxt    = sel_q;
            target_nxt = sel_tgt;
            to_err_nxt = 1'b0;
            if (!sel_ok) sel_err_nxt = 1'b1;
          end
        end

        S_GATE: begin
          if (cnt == '0) ns = S_SETTLE;
        end

        S_SETTLE: begin
          if (cnt == '0) ns = S_WAIT;
        end

        S_WAIT: begin
          if (lock_s2) begin
            ns = S_HOLD;
          end else if (cnt == '0) begin
            to_err_nxt = 1'b1;
`ifdef CLOCK_SWITCH_AUTO_FALLBACK_EN
            // One fallback attempt: once the target is the default, a
            // further timeout lands in FAULT.
            if (target != DEF_SEL) begin
              target_nxt = DEF_SEL;
              ns         = S_GATE;
            end else begin
              ns = S_FAULT;
            end
`else
            ns = S_FAULT;
`endif
          end
        end

        S_HOLD: begin
          // Lock dropping before release is not counted as a retry.
          if (!lock_s2) begin
            ns = S_GATE;
          end else if (cnt == '0) begin
            ns = S_RUN;
          end
        end

        S_RUN: begin
          if (!lock_s2) begin
            ns = S_GATE;
            if (retry_r != RETRY_MAX) retry_nxt = retry_r + RETRY_ONE;
          end
          if (sel_q != req_sel) begin
            ns         = S_GATE;
            req_nxt    = sel_q;
            target_nxt = sel_tgt;
            if (!sel_ok) sel_err_nxt = 1'b1;
          end
        end

        S_FAULT: begin
          if (sel_q != req_sel) begin
            ns         = S_GATE;
            req_nxt    = sel_q;
            target_nxt = sel_tgt;
            if (!sel_ok) sel_err_nxt = 1'b1;
          end
        end

        default: ns = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Process 3: outputs, decoded from the next state and registered on the
  // same edge as the state, so every output changes exactly on state entry.
  // The mux select only moves on SETTLE entry, when the gate was closed
  // during the preceding GATE cycles.
  // ---------------------------------------------------------------------
  always_comb begin
    mux_sel_d = mux_sel_r;
    mux_en_d  = 1'b0;
    pd_n_d    = 1'b0;
    rst_out_d = 1'b0;
    locked_d  = 1'b0;
    case (ns)
      S_SETTLE: begin
        mux_en_d = 1'b1;
        if (state != S_SETTLE) mux_sel_d = target_nxt;
      end
      S_WAIT,
      S_HOLD: begin
        mux_en_d = 1'b1;
        pd_n_d   = 1'b1;
      end
      S_RUN: begin
        mux_en_d  = 1'b1;
        pd_n_d    = 1'b1;
        rst_out_d = 1'b1;
        locked_d  = 1'b1;
      end
      default: begin
        mux_en_d  = 1'b0;
        pd_n_d    = 1'b0;
        rst_out_d = 1'b0;
        locked_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      target    <= DEF_SEL;
      req_sel   <= DEF_SEL;
      sel_err_r <= 1'b0;
      to_err_r  <= 1'b0;
      retry_r   <= '0;
      mux_sel_r <= DEF_SEL;
      mux_en_r  <= 1'b0;
      pd_n_r    <= 1'b0;
      rst_out_r <= 1'b0;
      locked_r  <= 1'b0;
    end else begin
      target    <= target_nxt;
      req_sel   <= req_nxt;
      sel_err_r <= sel_err_nxt;
      to_err_r  <= to_err_nxt;
      retry_r   <= retry_nxt;
      mux_sel_r <= mux_sel_d;
      mux_en_r  <= mux_en_d;
      pd_n_r    <= pd_n_d;
      rst_out_r <= rst_out_d;
      locked_r  <= locked_d;
    end
  end

  assign bus.Mux_Select      = mux_sel_r;
  assign bus.Mux_Enable      = mux_en_r;
  assign bus.PLL_PowerDown_N = pd_n_r;
  assign bus.Reset_N_OUT     = rst_out_r;
  assign bus.Locked          = locked_r;
  assign bus.Timeout_Err     = to_err_r;
  assign bus.Sel_Err         = sel_err_r;
  assign bus.Retry_Count     = retry_r;
  assign bus.State           = state;

endmodule

// File: tb/tb_clock_switch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_clock_switch_sequencer
//
// Drives two sequencers: u_dut (4 inputs, LOCK_TIMEOUT=64) for the main
// sequences and u_dut3 (3 inputs) for the out-of-range select case.
// Expected output snapshots are queued when stimulus is applied and popped
// when the matching edge has passed. Edge n counts from the first rising
// edge after the stimulus change (edge 0 = edge that samples it).
// ---------------------------------------------------------------------------
module tb_clock_switch_sequencer;

  localparam int W = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_GATE   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;
  localparam logic [2:0] ST_RUN    = 3'd5;
  localparam logic [2:0] ST_FAULT  = 3'd6;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clock_switch_sequencer_if #(.SEL_W(2), .RETRY_W(4)) bus  ();
  clock_switch_sequencer_if #(.SEL_W(2), .RETRY_W(4)) bus3 ();

  clock_switch_sequencer #(
    .NUM_INPUTS(4), .SEL_W(2), .DEFAULT_SEL(0), .PD_CYCLES(4),
    .LOCK_TIMEOUT(64), .RST_HOLD(8), .RETRY_W(4)
  ) u_dut (
    .Clock   (clk),
    .Reset_N (rst_n),
    .bus     (bus)
  );

  clock_switch_sequencer #(
    .NUM_INPUTS(3), .SEL_W(2), .DEFAULT_SEL(0), .PD_CYCLES(4),
    .LOCK_TIMEOUT(64), .RST_HOLD(8), .RETRY_W(4)
  ) u_dut3 (
    .Clock   (clk),
    .Reset_N (rst_n),
    .bus     (bus3)
  );

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  int cur_edge = -1;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] vec(input logic [2:0] st, input logic [1:0] sel,
                                       input logic en, input logic pd, input logic rs,
                                       input logic lk, input logic to, input logic se,
                                       input logic [3:0] rc);
    return {1'b0, st, sel, en, pd, rs, lk, to, se, rc};
  endfunction

  function automatic logic [W-1:0] snap();
    return {1'b0, bus.State, bus.Mux_Select, bus.Mux_Enable, bus.PLL_PowerDown_N,
            bus.Reset_N_OUT, bus.Locked, bus.Timeout_Err, bus.Sel_Err, bus.Retry_Count};
  endfunction

  function automatic logic [W-1:0] snap3();
    return {1'b0, bus3.State, bus3.Mux_Select, bus3.Mux_Enable, bus3.PLL_PowerDown_N,
            bus3.Reset_N_OUT, bus3.Locked, bus3.Timeout_Err, bus3.Sel_Err, bus3.Retry_Count};
  endfunction

  task automatic expect_push(input logic [W-1:0] e);
    exp_q.push_back(e);
  endtask

  task automatic compare_pop(input string tag, input logic [W-1:0] got);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got %h expected <queue empty>", tag, got);
    end else begin
      e = exp_q.pop_front();
      check(tag, got, e);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic origin();
    cur_edge = -1;
  endtask

  task automatic to_edge(input int n);
    step(n - cur_edge);
    cur_edge = n;
  endtask

  // Gate/power ordering monitor on u_dut
  logic       p_en, p_pd, p_rst;
  logic [1:0] p_sel;
  int         en_run = 0;
  always begin
    @(negedge clk);
    p_en  = bus.Mux_Enable;
    p_pd  = bus.PLL_PowerDown_N;
    p_sel = bus.Mux_Select;
    p_rst = rst_n;
    if (bus.Mux_Enable) en_run++;
    else en_run = 0;
    @(posedge clk);
    #1;
    if (p_rst && rst_n) begin
      if (bus.Mux_Select != p_sel)
        check("sel_change_gated", W'(p_en), W'(0));
      if (bus.PLL_PowerDown_N && !p_pd)
        check("pd_after_enable", W'(en_run >= 4), W'(1));
    end
  end

  logic [1:0] run_sel;
  logic [3:0] rc;

  initial begin
    bus.SwitchEnable  = 1'b1;
    bus.SwitchSelect  = 2'd2;
    bus.PLL_Lock      = 1'b1;
    bus3.SwitchEnable = 1'b0;
    bus3.SwitchSelect = 2'd0;
    bus3.PLL_Lock     = 1'b0;

    // reset values
    step(2);
    expect_push(vec(ST_IDLE, 2'd0, 0, 0, 0, 0, 0, 0, 4'd0));
    compare_pop("reset_vals", snap());
    rst_n = 1'b1;

    // power-up with select 2
    origin();
    expect_push(vec(ST_IDLE,   2'd0, 0, 0, 0, 0, 0, 0, 4'd0));
    expect_push(vec(ST_GATE,   2'd0, 0, 0, 0, 0, 0, 0, 4'd0));
    expect_push(vec(ST_GATE,   2'd0, 0, 0, 0, 0, 0, 0, 4'd0));
    expect_push(vec(ST_SETTLE, 2'd2, 1, 0, 0, 0, 0, 0, 4'd0));
    expect_push(vec(ST_SETTLE, 2'd2, 1, 0, 0, 0, 0, 0, 4'd0));
    expect_push(vec(ST_WAIT,   2'd2, 1, 1, 0, 0, 0, 0, 4'd0));
    expect_push(vec(ST_HOLD,   2'd2, 1, 1, 0, 0, 0, 0, 4'd0));
    expect_push(vec(ST_HOLD,   2'd2, 1, 1, 0, 0, 0, 0, 4'd0));
    expect_push(vec(ST_RUN,    2'd2, 1, 1, 1, 1, 0, 0, 4'd0));
    to_edge(0);  compare_pop("pu_e0_idle", snap());
    to_edge(1);  compare_pop("pu_e1_gate", snap());
    to_edge(4);  compare_pop("pu_e4_gate", snap());
    to_edge(5);  compare_pop("pu_e5_settle", snap());
    to_edge(8);  compare_pop("pu_e8_settle", snap());
    to_edge(9);  compare_pop("pu_e9_wait", snap());
    to_edge(10); compare_pop("pu_e10_hold", snap());
    to_edge(17); compare_pop("pu_e17_hold", snap());
    to_edge(18); compare_pop("pu_e18_run", snap());

    // first lock loss, 10 cycles low
    origin();
    bus.PLL_Lock = 1'b0;
    expect_push(vec(ST_RUN,    2'd2, 1, 1, 1, 1, 0, 0, 4'd0));
    expect_push(vec(ST_GATE,   2'd2, 0, 0, 0, 0, 0, 0, 4'd1));
    expect_push(vec(ST_SETTLE, 2'd2, 1, 0, 0, 0, 0, 0, 4'd1));
    expect_push(vec(ST_WAIT,   2'd2, 1, 1, 0, 0, 0, 0, 4'd1));
    expect_push(vec(ST_WAIT,   2'd2, 1, 1, 0, 0, 0, 0, 4'd1));
    expect_push(vec(ST_HOLD,   2'd2, 1, 1, 0, 0, 0, 0, 4'd1));
    expect_push(vec(ST_RUN,    2'd2, 1, 1, 1, 1, 0, 0, 4'd1));
    to_edge(1);  compare_pop("ll_e1_run", snap());
    to_edge(2);  compare_pop("ll_e2_gate", snap());
    to_edge(6);  compare_pop("ll_e6_settle", snap());
    to_edge(9);
    bus.PLL_Lock = 1'b1;
    to_edge(10); compare_pop("ll_e10_wait", snap());
    to_edge(11); compare_pop("ll_e11_wait", snap());
    to_edge(12); compare_pop("ll_e12_hold", snap());
    to_edge(20); compare_pop("ll_e20_run", snap());

    // repeated losses up to and past saturation
    for (int i = 2; i <= 16; i++) begin
      origin();
      bus.PLL_Lock = 1'b0;
      rc = (i > 15) ? 4'd15 : 4'(i);
      expect_push(vec(ST_RUN, 2'd2, 1, 1, 1, 1, 0, 0, rc));
      to_edge(9);
      bus.PLL_Lock = 1'b1;
      to_edge(20);
      compare_pop($sformatf("ll_rerun_%0d", i), snap());
    end

    // select change in RUN
    origin();
    bus.SwitchSelect = 2'd1;
    expect_push(vec(ST_RUN,    2'd2, 1, 1, 1, 1, 0, 0, 4'd15));
    expect_push(vec(ST_GATE,   2'd2, 0, 0, 0, 0, 0, 0, 4'd15));
    expect_push(vec(ST_SETTLE, 2'd1, 1, 0, 0, 0, 0, 0, 4'd15));
    expect_push(vec(ST_RUN,    2'd1, 1, 1, 1, 1, 0, 0, 4'd15));
    to_edge(0);  compare_pop("sc_e0_run", snap());
    to_edge(1);  compare_pop("sc_e1_gate", snap());
    to_edge(5);  compare_pop("sc_e5_settle", snap());
    to_edge(18); compare_pop("sc_e18_run", snap());

    // disable in RUN
    origin();
    bus.SwitchEnable = 1'b0;
    expect_push(vec(ST_RUN,  2'd1, 1, 1, 1, 1, 0, 0, 4'd15));
    expect_push(vec(ST_IDLE, 2'd1, 0, 0, 0, 0, 0, 0, 4'd15));
    to_edge(0); compare_pop("dis_e0_run", snap());
    to_edge(1); compare_pop("dis_e1_idle", snap());

    // lock timeout on select 3
    origin();
    bus.PLL_Lock     = 1'b0;
    bus.SwitchSelect = 2'd3;
    bus.SwitchEnable = 1'b1;
    expect_push(vec(ST_GATE,   2'd1, 0, 0, 0, 0, 0, 0, 4'd15));
    expect_push(vec(ST_SETTLE, 2'd3, 1, 0, 0, 0, 0, 0, 4'd15));
    expect_push(vec(ST_WAIT,   2'd3, 1, 1, 0, 0, 0, 0, 4'd15));
    expect_push(vec(ST_WAIT,   2'd3, 1, 1, 0, 0, 0, 0, 4'd15));
`ifdef CLOCK_SWITCH_AUTO_FALLBACK_EN
    expect_push(vec(ST_GATE,   2'd3, 0, 0, 0, 0, 1, 0, 4'd15));
`else
    expect_push(vec(ST_FAULT,  2'd3, 0, 0, 0, 0, 1, 0, 4'd15));
`endif
    to_edge(1);  compare_pop("to_e1_gate", snap());
    to_edge(5);  compare_pop("to_e5_settle", snap());
    to_edge(9);  compare_pop("to_e9_wait", snap());
    to_edge(72); compare_pop("to_e72_wait", snap());
    to_edge(73); compare_pop("to_e73_timeout", snap());

`ifdef CLOCK_SWITCH_AUTO_FALLBACK_EN
    // fallback to input 0, lock there
    expect_push(vec(ST_SETTLE, 2'd0, 1, 0, 0, 0, 1, 0, 4'd15));
    expect_push(vec(ST_RUN,    2'd0, 1, 1, 1, 1, 1, 0, 4'd15));
    to_edge(77); compare_pop("fb_e77_settle", snap());
    bus.PLL_Lock = 1'b1;
    to_edge(90); compare_pop("fb_e90_run", snap());
    run_sel = 2'd0;
`else
    // leave FAULT by changing the select
    origin();
    bus.SwitchSelect = 2'd2;
    bus.PLL_Lock     = 1'b1;
    expect_push(vec(ST_GATE,   2'd3, 0, 0, 0, 0, 1, 0, 4'd15));
    expect_push(vec(ST_SETTLE, 2'd2, 1, 0, 0, 0, 1, 0, 4'd15));
    expect_push(vec(ST_RUN,    2'd2, 1, 1, 1, 1, 1, 0, 4'd15));
    to_edge(1);  compare_pop("ft_e1_gate", snap());
    to_edge(5);  compare_pop("ft_e5_settle", snap());
    to_edge(18); compare_pop("ft_e18_run", snap());
    run_sel = 2'd2;
`endif

    // disable mid-WAIT_LOCK
    origin();
    bus.SwitchEnable = 1'b0;
    expect_push(vec(ST_IDLE, run_sel, 0, 0, 0, 0, 1, 0, 4'd15));
    to_edge(1); compare_pop("dw_idle_first", snap());
    origin();
    bus.PLL_Lock     = 1'b0;
    bus.SwitchSelect = 2'd1;
    bus.SwitchEnable = 1'b1;
    expect_push(vec(ST_WAIT, 2'd1, 1, 1, 0, 0, 0, 0, 4'd15));
    to_edge(9); compare_pop("dw_e9_wait", snap());
    origin();
    bus.SwitchEnable = 1'b0;
    expect_push(vec(ST_WAIT, 2'd1, 1, 1, 0, 0, 0, 0, 4'd15));
    expect_push(vec(ST_IDLE, 2'd1, 0, 0, 0, 0, 0, 0, 4'd15));
    to_edge(0); compare_pop("dw_e0_wait", snap());
    to_edge(1); compare_pop("dw_e1_idle", snap());

    // asynchronous reset while in HOLD
    origin();
    bus.PLL_Lock     = 1'b1;
    bus.SwitchSelect = 2'd2;
    bus.SwitchEnable = 1'b1;
    expect_push(vec(ST_HOLD, 2'd2, 1, 1, 0, 0, 0, 0, 4'd15));
    expect_push(vec(ST_IDLE, 2'd0, 0, 0, 0, 0, 0, 0, 4'd0));
    to_edge(12); compare_pop("ar_e12_hold", snap());
    #2;
    rst_n = 1'b0;
    #1;
    compare_pop("ar_async_vals", snap());
    step(2);
    rst_n = 1'b1;

    // out-of-range select on the 3-input instance
    origin();
    bus3.PLL_Lock     = 1'b1;
    bus3.SwitchSelect = 2'd3;
    bus3.SwitchEnable = 1'b1;
    expect_push(vec(ST_GATE,   2'd0, 0, 0, 0, 0, 0, 1, 4'd0));
    expect_push(vec(ST_SETTLE, 2'd0, 1, 0, 0, 0, 0, 1, 4'd0));
    expect_push(vec(ST_RUN,    2'd0, 1, 1, 1, 1, 0, 1, 4'd0));
    expect_push(vec(ST_RUN,    2'd0, 1, 1, 1, 1, 0, 1, 4'd0));
    to_edge(1);  compare_pop("oor_e1_gate", snap3());
    to_edge(5);  compare_pop("oor_e5_settle", snap3());
    to_edge(18); compare_pop("oor_e18_run", snap3());
    to_edge(30); compare_pop("oor_e30_stays_run", snap3());

    check("exp_q_drained", W'(exp_q.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/clock_switch_sequencer.md
# clock_switch_sequencer

Parametrised successor to the fixed four-input clock switch in the clock/reset subsystem. It selects one of `NUM_INPUTS` reference clocks for a downstream fabric PLL and sequences each change: gate, power down, switch, power up, wait for lock with timeout, hold reset, release. It also monitors lock loss and retries. The block runs entirely in the control clock domain. It drives the select and enable of an external glitch-free clock mux and the PLL powerdown, and produces the logic-domain reset request for the selected clock.

## Interface
Parameters:
- `NUM_INPUTS`, default 4: number of selectable reference clocks (2..16).
- `SEL_W`, default 2: select width; must satisfy 2^SEL_W ≥ NUM_INPUTS.
- `DEFAULT_SEL`, default 0: select used after reset and as the fallback target.
- `PD_CYCLES`, default 4: cycles spent in GATE and again in SETTLE (≥1).
- `LOCK_TIMEOUT`, default 4096: maximum WAIT_LOCK cycles before a timeout.
- `RST_HOLD`, default 8: cycles `Reset_N_OUT` stays low after lock (≥1).
- `RETRY_W`, default 4: width of the lock-loss retry counter.

Ports:
- `Clock` in 1: control clock; every register is clocked here.
- `Reset_N` in 1: asynchronous, active-low reset.
- `SwitchEnable` in 1: level; 1 means a clock should be running.
- `SwitchSelect` in SEL_W: requested input.
- `PLL_Lock` in 1: asynchronous PLL lock, double-flop synchronised inside the block.
- `Mux_Select` out SEL_W: select for the external glitch-free mux.
- `Mux_Enable` out 1: mux output enable / clock gate.
- `PLL_PowerDown_N` out 1: 0 means the PLL is powered down.
- `Reset_N_OUT` out 1: reset request for the selected domain; the consumer resynchronises it.
- `Locked` out 1: 1 only in the RUN state.
- `Timeout_Err` out 1: sticky lock-timeout flag.
- `Sel_Err` out 1: sticky flag for an out-of-range select.
- `Retry_Count` out RETRY_W: number of lock losses seen in RUN, saturating.
- `State` out 3: encoded current state.

## Operation
States and their encoding: IDLE=0, GATE=1, SETTLE=2, WAIT_LOCK=3, HOLD=4, RUN=5, FAULT=6.

Reset values of all outputs:
- State=IDLE, `Mux_Select`=DEFAULT_SEL, `Mux_Enable`=0, `PLL_PowerDown_N`=0, `Reset_N_OUT`=0.
- `Locked`=0, `Timeout_Err`=0, `Sel_Err`=0, `Retry_Count`=0.

State behaviour:
- **IDLE**: all gates closed. When `SwitchEnable`=1, latch target=`SwitchSelect`. If that value is ≥ NUM_INPUTS, use target=DEFAULT_SEL and set `Sel_Err`. Clear `Timeout_Err`. Next state is GATE.
- **GATE**: `Mux_Enable`=0, `PLL_PowerDown_N`=0, `Reset_N_OUT`=0. The previous `Mux_Select` is held. After PD_CYCLES cycles, go to SETTLE.
- **SETTLE**: `Mux_Select`=target on the first cycle; `Mux_Enable`=1; PLL still powered down. After PD_CYCLES cycles, go to WAIT_LOCK.
- **WAIT_LOCK**: `PLL_PowerDown_N`=1, timeout counter running.
  - Synchronised lock = 1 → HOLD.
  - Counter reaches LOCK_TIMEOUT with no lock → set `Timeout_Err`, then follow the fallback rule in Configuration.
- **HOLD**: counts RST_HOLD cycles, then RUN. If synchronised lock drops during HOLD, go back to GATE; `Retry_Count` is not incremented.
- **RUN**: `Reset_N_OUT`=1, `Locked`=1.
  - Synchronised lock falls → `Retry_Count` +1 (saturating), `Reset_N_OUT`=0 in the same cycle, go to GATE with the same target.
  - `SwitchSelect` ≠ active target → latch the new target (range check as in IDLE), go to GATE.
- **FAULT**: all outputs as in GATE. Leave for GATE when `SwitchSelect` changes; leave for IDLE when `SwitchEnable`=0.
- **Disable**: `SwitchEnable`=0 in any state except IDLE → next state IDLE. Outputs take their closed values on that same transition edge.
- **Simultaneous events**:
  - Disable has priority over lock loss, which has priority over a select change.
  - Lock loss and a select change in the same cycle: the counter increments and the new target is latched.
- **Counters**: a single down-counter of width clog2(max(LOCK_TIMEOUT, PD_CYCLES, RST_HOLD)+1), reloaded on every state entry.
- **Reset mid-sequence**: asynchronous return to the reset values. No partial state survives.

## Timing
- `PLL_Lock` to internal use: 2 cycles of synchroniser latency.
- All outputs are registered; none is combinational from an input.
- Edge numbering: `SwitchEnable` sampled high at edge 0 → GATE entered at edge 1 → SETTLE at 1+PD_CYCLES → WAIT_LOCK at 1+2·PD_CYCLES.
- If lock is already synchronised, HOLD is entered one cycle after WAIT_LOCK, and `Reset_N_OUT` rises at edge 2+2·PD_CYCLES+RST_HOLD.
- With defaults (PD_CYCLES=4, RST_HOLD=8), `Reset_N_OUT` rises at edge 18.
- `Mux_Enable` is never 1 in the same cycle that `Mux_Select` changes.
- `PLL_PowerDown_N` rises only when `Mux_Enable` has been 1 for PD_CYCLES cycles.

## Configuration
- Macro `CLOCK_SWITCH_AUTO_FALLBACK_EN`.
- **Defined**: on timeout with target ≠ DEFAULT_SEL, set target=DEFAULT_SEL and go to GATE, giving one fallback attempt. On timeout with target = DEFAULT_SEL, go to FAULT.
- **Undefined**: every timeout goes to FAULT.

## Test plan
- **Power-up, defaults**: deassert reset, `PLL_Lock`=1, `SwitchEnable`=1, select 2 → `Mux_Select`=2 at edge 5, `PLL_PowerDown_N`=1 at edge 9, `Reset_N_OUT`=1 and `Locked`=1 at edge 18.
- **Lock loss in RUN**: drop `PLL_Lock` for 10 cycles → `Reset_N_OUT`=0 two cycles later, `Retry_Count`=1, full resequence back to RUN; repeat past 2^RETRY_W losses → count saturates at 15.
- **Timeout**: LOCK_TIMEOUT=64, `PLL_Lock`=0, select 3.
  - Macro undefined → `Timeout_Err`=1, State=6.
  - Macro defined → `Mux_Select` goes to 0, then lock at 0 → RUN.
- **Out-of-range select**: NUM_INPUTS=3, select 3 → `Sel_Err`=1, `Mux_Select`=0.
- **Disable mid-WAIT_LOCK**: `SwitchEnable`=0 → State=IDLE, `PLL_PowerDown_N`=0 next edge.
- **Async reset in HOLD**: all outputs take their reset values immediately, without waiting for a clock edge.
